// File: rtl/spinner_pkg.sv
// Shared definitions for the spinner tick path: speed codes, the nominal
// period of each code, and the detector FSM state type.
package spinner_pkg;

  localparam logic [3:0] SPD_1HZ  = 4'b0000;
  localparam logic [3:0] SPD_2HZ  = 4'b0001;
  localparam logic [3:0] SPD_4HZ  = 4'b0011;
  localparam logic [3:0] SPD_8HZ  = 4'b0111;
  localparam logic [3:0] SPD_16HZ = 4'b1111;
  localparam logic [3:0] SPD_TEST = 4'b1000;

  localparam int NCODES = 6;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  // Nominal tick period in clock cycles for a speed code.
  function automatic logic [63:0] nominal_limit(input logic [3:0] code,
                                                input logic [63:0] limit_1hz,
                                                input logic [63:0] test_limit);
    case (code)
      SPD_1HZ:  nominal_limit = limit_1hz;
      SPD_2HZ:  nominal_limit = limit_1hz >> 1;
      SPD_4HZ:  nominal_limit = limit_1hz >> 2;
      SPD_8HZ:  nominal_limit = limit_1hz >> 3;
      SPD_16HZ: nominal_limit = limit_1hz >> 4;
      SPD_TEST: nominal_limit = test_limit;
      default:  nominal_limit = '0;
    endcase
  endfunction

  // Classification order, lowest priority first: a later hit overrides an
  // earlier one, so 1 Hz beats faster codes and the test rate beats all.
  function automatic logic [3:0] code_at(input int idx);
    case (idx)
      0:       code_at = SPD_16HZ;
      1:       code_at = SPD_8HZ;
      2:       code_at = SPD_4HZ;
      3:       code_at = SPD_2HZ;
      4:       code_at = SPD_1HZ;
      default: code_at = SPD_TEST;
    endcase
  endfunction

endpackage

// File: rtl/speed_detector_if.sv
// Tick input and measurement result bundle of the speed detector.
interface speed_detector_if;
  logic       tick_i;
  logic [3:0] speed_o;
  logic       valid_o;
  logic       match_o;
  logic       locked_o;
  logic       timeout_o;

  modport master (output tick_i,
                  input  speed_o, valid_o, match_o, locked_o, timeout_o);
  modport slave  (input  tick_i,
                  output speed_o, valid_o, match_o, locked_o, timeout_o);
endinterface

// File: rtl/period_classifier.sv
// Maps a measured period onto a speed code using inclusive tolerance windows
// around each nominal period. Window bounds are elaboration-time constants.
module period_classifier
  import spinner_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int LIMIT_1HZ  = 50000000,
  parameter int TEST_LIMIT = 50000,
  parameter int TOL_SHIFT  = 4
) (
  input  logic [CNT_W-1:0] i_period,
  output logic [3:0]       o_code,
  output logic             o_match
);

  logic [NCODES-1:0] w_hit;

  for (genvar g = 0; g < NCODES; g++) begin : g_win
    localparam logic [CNT_W-1:0] NOM =
      CNT_W'(nominal_limit(code_at(g), 64'(LIMIT_1HZ), 64'(TEST_LIMIT)));
    localparam logic [CNT_W-1:0] LO = NOM - (NOM >> TOL_SHIFT);
    localparam logic [CNT_W-1:0] HI = NOM + (NOM >> TOL_SHIFT);
    assign w_hit[g] = (i_period >= LO) && (i_period <= HI);
  end

  // Priority select: later table entries override earlier ones.
  always_comb begin
    o_code  = '0;
    o_match = 1'b0;
    for (int i = 0; i < NCODES; i++) begin
      if (w_hit[i]) begin
        o_code  = code_at(i);
        o_match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/speed_detector.sv
// Measures the interval between tick pulses, classifies it into a speed code,
// tracks lock on a repeated code and flags loss of ticks.
module speed_detector
  import spinner_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int LIMIT_1HZ  = 50000000,
  parameter int TEST_LIMIT = 50000,
  parameter int TOL_SHIFT  = 4,
  parameter int TIMEOUT    = 100000000,
  parameter int LOCK_CNT   = 2
) (
  input logic             clk_i,
  input logic             rst_ni,
  speed_detector_if.slave bus
);

  localparam int                LW         = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [LW-1:0]     LOCK_LIM   = LW'(LOCK_CNT);
  localparam logic [CNT_W-1:0]  TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_take, w_timeout;

  logic [CNT_W-1:0] r_period_p0;
  logic             r_vld_p0;

  logic [3:0]       w_cls_code;
  logic             w_cls_match;

  logic [3:0]       r_speed_p1;
  logic             r_vld_p1, r_match_p1, r_timeout_p1;
  logic [LW-1:0]    r_lock_cnt, w_lock_cnt_nxt;

  // State and interval counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: a tick always wins over a timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.tick_i) begin
          w_state_nxt = ST_MEASURE;
          w_cnt_nxt   = '0;
        end
      end
      ST_MEASURE: begin
        if (bus.tick_i) begin
          w_take    = 1'b1;
          w_cnt_nxt = '0;
        end else if (r_cnt == TIMEOUT_M1) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---- stage p0: captured period ----
  // Period capture; only the valid flag needs reset.
  always_ff @(posedge clk_i) begin
    if (w_take) r_period_p0 <= r_cnt + CNT_W'(1);
  end

  // Valid flag travelling with the captured period.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_vld_p0 <= 1'b0;
    else         r_vld_p0 <= w_take;
  end

  period_classifier #(
    .CNT_W      (CNT_W),
    .LIMIT_1HZ  (LIMIT_1HZ),
    .TEST_LIMIT (TEST_LIMIT),
    .TOL_SHIFT  (TOL_SHIFT)
  ) u_cls (
    .i_period (r_period_p0),
    .o_code   (w_cls_code),
    .o_match  (w_cls_match)
  );

  // Lock counter update: repeat of the last matched code counts up.
  always_comb begin
    w_lock_cnt_nxt = r_lock_cnt;
    if (w_timeout) begin
      w_lock_cnt_nxt = '0;
    end else if (r_vld_p0) begin
      if (!w_cls_match)
        w_lock_cnt_nxt = '0;
      else if ((r_lock_cnt != '0) && (w_cls_code == r_speed_p1)) begin
        if (r_lock_cnt < LOCK_LIM) w_lock_cnt_nxt = r_lock_cnt + LW'(1);
      end else
        w_lock_cnt_nxt = LW'(1);
    end
  end

  // ---- stage p1: classification result ----
  // Result, lock and timeout registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_speed_p1   <= SPD_1HZ;
      r_vld_p1     <= 1'b0;
      r_match_p1   <= 1'b0;
      r_timeout_p1 <= 1'b0;
      r_lock_cnt   <= '0;
    end else begin
      r_vld_p1     <= r_vld_p0;
      r_timeout_p1 <= w_timeout;
      r_lock_cnt   <= w_lock_cnt_nxt;
      if (r_vld_p0) begin
        r_match_p1 <= w_cls_match;
        if (w_cls_match) r_speed_p1 <= w_cls_code;
      end
    end
  end

  assign bus.speed_o   = r_speed_p1;
  assign bus.valid_o   = r_vld_p1;
  assign bus.match_o   = r_match_p1;
  assign bus.timeout_o = r_timeout_p1;
  assign bus.locked_o  = (r_lock_cnt >= LOCK_LIM);

endmodule

// File: tb/tb_speed_detector.sv
// Directed bench for speed_detector with scaled-down periods.
module tb_speed_detector;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  speed_detector_if bus();

  speed_detector #(
    .CNT_W      (32),
    .LIMIT_1HZ  (800),
    .TEST_LIMIT (16),
    .TOL_SHIFT  (4),
    .TIMEOUT    (1600),
    .LOCK_CNT   (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         gap;
    logic       ev;
    logic       em;
    logic [3:0] es;
    logic       el;
  } vec_t;

  localparam int NV = 21;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_pulse();
    bus.tick_i = 1'b1;
    @(posedge clk);
    #1;
    bus.tick_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_speed"},   32'(bus.speed_o),   32'h0);
    chk({tag, "_valid"},   32'(bus.valid_o),   32'h0);
    chk({tag, "_match"},   32'(bus.match_o),   32'h0);
    chk({tag, "_locked"},  32'(bus.locked_o),  32'h0);
    chk({tag, "_timeout"}, 32'(bus.timeout_o), 32'h0);
  endtask

  initial begin
    int  k;
    bit  found;

    // gap = cycles since previous tick (0 = first tick from IDLE)
    vec[0]  = '{0,   1'b0, 1'b0, 4'b0000, 1'b0};
    vec[1]  = '{200, 1'b1, 1'b1, 4'b0011, 1'b0};
    vec[2]  = '{200, 1'b1, 1'b1, 4'b0011, 1'b1};
    vec[3]  = '{50,  1'b1, 1'b1, 4'b1111, 1'b0};
    vec[4]  = '{53,  1'b1, 1'b1, 4'b1111, 1'b1};
    vec[5]  = '{54,  1'b1, 1'b0, 4'b1111, 1'b0};
    vec[6]  = '{16,  1'b1, 1'b1, 4'b1000, 1'b0};
    vec[7]  = '{16,  1'b1, 1'b1, 4'b1000, 1'b1};
    vec[8]  = '{17,  1'b1, 1'b1, 4'b1000, 1'b1};
    vec[9]  = '{18,  1'b1, 1'b0, 4'b1000, 1'b0};
    vec[10] = '{400, 1'b1, 1'b1, 4'b0001, 1'b0};
    vec[11] = '{400, 1'b1, 1'b1, 4'b0001, 1'b1};
    vec[12] = '{800, 1'b1, 1'b1, 4'b0000, 1'b0};
    vec[13] = '{800, 1'b1, 1'b1, 4'b0000, 1'b1};
    vec[14] = '{750, 1'b1, 1'b1, 4'b0000, 1'b1};
    vec[15] = '{850, 1'b1, 1'b1, 4'b0000, 1'b1};
    vec[16] = '{851, 1'b1, 1'b0, 4'b0000, 1'b0};
    vec[17] = '{749, 1'b1, 1'b0, 4'b0000, 1'b0};
    vec[18] = '{15,  1'b1, 1'b1, 4'b1000, 1'b0};
    vec[19] = '{47,  1'b1, 1'b1, 4'b1111, 1'b0};
    vec[20] = '{212, 1'b1, 1'b1, 4'b0011, 1'b0};

    rst_n      = 1'b0;
    bus.tick_i = 1'b0;
    idle(3);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (vec[i].gap >= 3) idle(vec[i].gap - 3);
      tick_pulse();
      chk($sformatf("v%0d_valid_early", i), 32'(bus.valid_o), 32'h0);
      idle(1);
      chk($sformatf("v%0d_valid", i),  32'(bus.valid_o),  32'(vec[i].ev));
      chk($sformatf("v%0d_match", i),  32'(bus.match_o),  32'(vec[i].em));
      chk($sformatf("v%0d_speed", i),  32'(bus.speed_o),  32'(vec[i].es));
      chk($sformatf("v%0d_locked", i), 32'(bus.locked_o), 32'(vec[i].el));
      idle(1);
      chk($sformatf("v%0d_valid_len", i), 32'(bus.valid_o), 32'h0);
    end

    // reset 100 cycles into a measurement
    idle(98);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk_all_zero("midrst");
    tick_pulse();
    idle(1);
    chk("midrst_restart_v1", 32'(bus.valid_o), 32'h0);
    idle(1);
    chk("midrst_restart_v2", 32'(bus.valid_o), 32'h0);

    // reset while a matching result is in flight
    idle(797);
    tick_pulse();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("flight_valid", 32'(bus.valid_o), 32'h0);
    chk("flight_match", 32'(bus.match_o), 32'h0);
    idle(1);
    chk("flight_valid2", 32'(bus.valid_o), 32'h0);

    // one tick then silence
    tick_pulse();
    k = 0;
    found = 1'b0;
    while (!found && k < 2000) begin
      idle(1);
      k++;
      if (bus.valid_o) chk("to_no_valid", 32'(bus.valid_o), 32'h0);
      if (bus.timeout_o) found = 1'b1;
    end
    chk("to_seen", 32'(found), 32'h1);
    chk("to_delay", 32'(k), 32'd1600);
    chk("to_locked", 32'(bus.locked_o), 32'h0);
    idle(1);
    chk("to_pulse_len", 32'(bus.timeout_o), 32'h0);

    // next tick from IDLE only restarts timing
    tick_pulse();
    chk("post_to_v0", 32'(bus.valid_o), 32'h0);
    idle(1);
    chk("post_to_v1", 32'(bus.valid_o), 32'h0);
    idle(1);
    chk("post_to_v2", 32'(bus.valid_o), 32'h0);

    // tick on the exact timeout cycle: measurement taken, no timeout
    idle(1597);
    tick_pulse();
    chk("tie_timeout0", 32'(bus.timeout_o), 32'h0);
    idle(1);
    chk("tie_timeout1", 32'(bus.timeout_o), 32'h0);
    chk("tie_valid",    32'(bus.valid_o),   32'h1);
    chk("tie_match",    32'(bus.match_o),   32'h0);
    idle(1);
    chk("tie_timeout2", 32'(bus.timeout_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
